// File: rtl/bus_reg_slave.sv
// bus_reg_slave: req/gnt/rw bus responder that fronts a small register file.
// Each accepted request is granted after a programmable number of wait states.
// Read-only registers silently drop writes. Accesses beyond the register file
// complete normally but raise err together with gnt.
module bus_reg_slave #(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RST_VAL     = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         rw,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic                         gnt,
    output logic [DATA_W-1:0]            rdata,
    output logic                         err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(NUM_REGS);

    // One past the last valid byte address. The extra bit keeps the value
    // representable even when the register file fills the whole address space.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_REGS * BYTES);

    // Counter preload for the WAIT state. It is unused when there are no wait states.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic [3:0]            w_next_cnt;
    logic                  r_gnt;
    logic                  r_err;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_regs [NUM_REGS];

    logic [IDX_W-1:0]      w_idx;
    logic                  w_in_range;
    logic                  w_enter_grant;
    logic                  w_wr_en;

    // The address is decoded once. Low byte-offset bits are ignored.
    assign w_idx         = addr[OFF_W +: IDX_W];
    assign w_in_range    = ({1'b0, addr} < SPAN);
    assign w_enter_grant = (w_next_state == ST_GRANT);
    assign w_wr_en       = (r_state == ST_GRANT) && rw && w_in_range;

    // Next-state and wait counter logic. A request dropped in WAIT aborts the transfer.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        w_next_state = ST_GRANT;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = CNT_INIT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = ST_GRANT;
                end else begin
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            ST_GRANT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Response flops are loaded on entry to GRANT, so gnt, err and rdata line up.
    // Writes leave rdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_gnt <= w_enter_grant;
            r_err <= w_enter_grant && !w_in_range;
            if (w_enter_grant && !rw) begin
                r_rdata <= w_in_range ? r_regs[w_idx] : '0;
            end
        end
    end

    // Register file. A write commits on the edge that leaves GRANT.
    // Read-only registers ignore the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_en && (w_idx == IDX_W'(i)) && !RO_MASK[i]) begin
                    r_regs[i] <= wdata;
                end
            end
        end
    end

    assign gnt   = r_gnt;
    assign err   = r_err;
    assign rdata = r_rdata;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: tb/tb_bus_reg_slave.sv
// Self-checking bench for bus_reg_slave. There are two instances:
//   dut 0: WAIT_STATES=0, no read-only registers, RST_VAL=0x00005A5A
//   dut 1: WAIT_STATES=3, register 0 read-only,   RST_VAL=0xCAFE0000
// A reference model holds register contents and the last read value. It applies
// the bus rules directly: byte address / 4 gives the register, an address of 32 or
// more is out of range, and the latency is WAIT_STATES+1 cycles.
module tb_bus_reg_slave;

    localparam logic [31:0] RST0 = 32'h0000_5A5A;
    localparam logic [31:0] RST1 = 32'hCAFE_0000;
    localparam logic [7:0]  RO0  = 8'h00;
    localparam logic [7:0]  RO1  = 8'h01;

    logic         clk;
    logic         rst_n  [2];
    logic         req    [2];
    logic         rw     [2];
    logic [31:0]  addr   [2];
    logic [31:0]  wdata  [2];
    logic         gnt    [2];
    logic         err    [2];
    logic [31:0]  rdata  [2];
    logic [255:0] regs_o [2];

    logic [31:0]  m_regs  [2][8];
    logic [31:0]  m_rdata [2];

    int checks = 0;
    int errors = 0;

    bus_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(0),
                    .RO_MASK(RO0), .RST_VAL(RST0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .rw(rw[0]), .addr(addr[0]),
        .wdata(wdata[0]), .gnt(gnt[0]), .rdata(rdata[0]), .err(err[0]),
        .regs_o(regs_o[0]));

    bus_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(3),
                    .RO_MASK(RO1), .RST_VAL(RST1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .rw(rw[1]), .addr(addr[1]),
        .wdata(wdata[1]), .gnt(gnt[1]), .rdata(rdata[1]), .err(err[1]),
        .regs_o(regs_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [7:0] ro_of(input int d);
        return (d == 0) ? RO0 : RO1;
    endfunction

    function automatic logic [31:0] rst_of(input int d);
        return (d == 0) ? RST0 : RST1;
    endfunction

    function automatic logic [255:0] model_flat(input int d);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_regs[d][i];
        return v;
    endfunction

    task automatic model_reset(input int d);
        for (int i = 0; i < 8; i++) m_regs[d][i] = rst_of(d);
        m_rdata[d] = 32'h0;
    endtask

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer. It is entered and left just after a falling edge.
    // keep_req leaves req high for a back-to-back follow-up.
    task automatic do_xfer(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input bit keep_req);
        int   cyc;
        bit   got;
        bit   inr;
        int   idx;
        logic [7:0] ro;
        rw[d] = w; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
        cyc = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            got = gnt[d];
        end
        inr = (a < 32'd32);
        idx = int'(a / 32'd4) % 8;
        ro  = ro_of(d);
        if (!got) begin
            check_val("gnt_timeout", 256'd0, 256'd1);
        end else begin
            check_val("latency", 256'(cyc), 256'(ws_of(d) + 1));
            if (!w) m_rdata[d] = inr ? m_regs[d][idx] : 32'h0;
            check_val("err", 256'(err[d]), 256'(!inr));
            check_val("rdata", 256'(rdata[d]), 256'(m_rdata[d]));
        end
        if (!keep_req) req[d] = 1'b0;
        if (w && inr && !ro[idx]) m_regs[d][idx] = wd;
        @(negedge clk);
        check_val("gnt_pulse", 256'(gnt[d]), 256'd0);
        check_val("err_idle", 256'(err[d]), 256'd0);
        check_val("rdata_hold", 256'(rdata[d]), 256'(m_rdata[d]));
        check_val("regs_o", regs_o[d], model_flat(d));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; rw[d] = 1'b0;
            addr[d] = 32'h0; wdata[d] = 32'h0;
            model_reset(d);
        end
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val("rst_gnt", 256'(gnt[d]), 256'd0);
            check_val("rst_err", 256'(err[d]), 256'd0);
            check_val("rst_rdata", 256'(rdata[d]), 256'd0);
            check_val("rst_regs", regs_o[d], model_flat(d));
        end

        // Zero wait states: write and read back the same register.
        do_xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0);
        do_xfer(0, 1'b0, 32'h04, 32'h0, 1'b0);
        check_val("reg1_slice", 256'(regs_o[0][63:32]), 256'(32'hDEAD_BEEF));

        // Out-of-range write and read.
        do_xfer(0, 1'b1, 32'h20, 32'h1111_2222, 1'b0);
        do_xfer(0, 1'b0, 32'h7C, 32'h0, 1'b0);

        // Back-to-back writes to registers 0..3 with req held throughout.
        do_xfer(0, 1'b1, 32'h00, 32'hA0A0_0000, 1'b1);
        do_xfer(0, 1'b1, 32'h04, 32'hA1A1_1111, 1'b1);
        do_xfer(0, 1'b1, 32'h08, 32'hA2A2_2222, 1'b1);
        do_xfer(0, 1'b1, 32'h0C, 32'hA3A3_3333, 1'b0);

        // Random traffic, including unaligned and out-of-range addresses.
        for (int n = 0; n < 40; n++)
            do_xfer(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 47)), $urandom, 1'b0);

        // Three wait states: read at address 0.
        do_xfer(1, 1'b0, 32'h00, 32'h0, 1'b0);

        // Abort: drop req after two cycles of waiting, so no gnt and no write.
        rw[1] = 1'b1; addr[1] = 32'h08; wdata[1] = 32'h5555_AAAA; req[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("abort_wait_gnt", 256'(gnt[1]), 256'd0);
        end
        req[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("abort_no_gnt", 256'(gnt[1]), 256'd0);
        end
        check_val("abort_regs", regs_o[1], model_flat(1));
        do_xfer(1, 1'b0, 32'h08, 32'h0, 1'b0);

        // A write to the read-only register 0 completes normally but changes nothing.
        do_xfer(1, 1'b1, 32'h00, 32'h0000_1234, 1'b0);

        for (int n = 0; n < 20; n++)
            do_xfer(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 47)), $urandom, 1'b0);

        // Reset in the middle of WAIT, after a read has left rdata non-zero.
        do_xfer(1, 1'b0, 32'h0C, 32'h0, 1'b0);
        rw[1] = 1'b1; addr[1] = 32'h08; wdata[1] = 32'h0000_00A5; req[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        model_reset(1);
        check_val("midrst_gnt", 256'(gnt[1]), 256'd0);
        check_val("midrst_err", 256'(err[1]), 256'd0);
        check_val("midrst_rdata", 256'(rdata[1]), 256'd0);
        check_val("midrst_regs", regs_o[1], model_flat(1));
        req[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        check_val("postrst_reg2", 256'(regs_o[1][95:64]), 256'(RST1));
        check_val("postrst_gnt", 256'(gnt[1]), 256'd0);
        do_xfer(1, 1'b0, 32'h08, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
